rpmp_host_link: RTL and testbench

Host-side transaction engine between the MSX bus capture logic and the Raspberry Pi parallel link. It queues captured MSX bus events (address, data, direction, space) in a small FIFO. It serves them to the Pi over the 16-bit `r` bus using the RATN/ack four-phase handshake and the 2-bit `cmd` code. It also holds the Pi-written control state (wait, interrupt, read-return data, I/O-port claim table) that the bus-facing stage consumes.

---
 rtl/rpmp_pkg.sv | 43 ++++
 rtl/rpmp_event_fifo.sv | 56 +++++
 rtl/rpmp_host_link.sv | 126 ++++++++++++
 tb/tb_rpmp_host_link.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rpmp_pkg.sv
// Shared encodings and the event record for the MSX-to-Pi host link.
// Holds no logic apart from the INFO word packer used by the handshake stage.
package rpmp_pkg;

    localparam logic [1:0] CMD_PEEK_ADDR  = 2'b00;
    localparam logic [1:0] CMD_POP_INFO   = 2'b01;
    localparam logic [1:0] CMD_WRITE_DATA = 2'b10;
    localparam logic [1:0] CMD_CONTROL    = 2'b11;

    localparam int CTL_WAIT    = 15;
    localparam int CTL_INT     = 14;
    localparam int CTL_CLAIM   = 13;
    localparam int CTL_UNCLAIM = 12;
    localparam int CTL_OVF_CLR = 11;

    localparam int INFO_RW    = 15;
    localparam int INFO_IOMEM = 14;
    localparam int INFO_EMPTY = 13;
    localparam int INFO_OVF   = 12;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rw;
        logic        iomem;
    } ev_t;

    // Head fields are only meaningful when the queue holds something.
    function automatic logic [15:0] info_word(input ev_t h, input logic empty, input logic ovf);
        logic [15:0] w;
        w = '0;
        if (empty) begin
            w[INFO_EMPTY] = 1'b1;
        end else begin
            w[INFO_RW]    = h.rw;
            w[INFO_IOMEM] = h.iomem;
            w[7:0]        = h.data;
        end
        w[INFO_OVF] = ovf;
        return w;
    endfunction

endpackage

// File: rtl/rpmp_event_fifo.sv
// Generic synchronous FIFO; head is read combinationally, push/pop take effect on the clock edge.
// Latency 1 cycle push-to-head; push is refused while full even if a pop happens in the same cycle.
module rpmp_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 26
) (
    input  logic                     gclk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_nxt;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push_ok) count_nxt = count_nxt + 1'b1;
        if (pop_ok)  count_nxt = count_nxt - 1'b1;
    end

    always_ff @(posedge gclk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge gclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/rpmp_host_link.sv
// Queues MSX bus events and serves them to the Pi over r/cmd with a RATN/ack four-phase handshake.
// Latency RATN edge to ack edge 3-4 gclk; events offered while the queue is full are dropped and flagged.
module rpmp_host_link
    import rpmp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        gclk,
    input  logic        reset,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic [15:0] ev_addr,
    input  logic [7:0]  ev_data,
    input  logic        ev_rw,
    input  logic        ev_iomem,
    input  logic        RATN,
    input  logic [1:0]  cmd,
    input  logic [15:0] r_in,
    output logic [15:0] r_out,
    output logic        r_oe,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        rwait,
    output logic        rint,
    input  logic [7:0]  io_port,
    output logic        io_claimed
);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    logic [0:0]    state;
    logic [2:0]    ratn_s;
    logic          rise;
    logic          fall;
    logic          start;
    logic          overflow;
    logic          ovf_set;
    logic          ovf_clr;
    logic          pop;
    logic [255:0]  claim_tbl;
    ev_t           ev_in;
    ev_t           head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    assign rise  = (ratn_s[2:1] == 2'b01);
    assign fall  = (ratn_s[2:1] == 2'b10);
    // A rise while ack is still high breaks the protocol and is ignored.
    assign start = rise && (state == ST_IDLE);
    assign pop   = start && (cmd == CMD_POP_INFO) && (fifo_count != '0);

    assign ev_in      = '{addr: ev_addr, data: ev_data, rw: ev_rw, iomem: ev_iomem};
    assign ev_ready   = !fifo_full;
    assign ack        = (state == ST_ACK);
    assign io_claimed = claim_tbl[io_port];

    assign ovf_set = ev_valid && fifo_full;
    assign ovf_clr = start && (cmd == CMD_CONTROL) && r_in[CTL_OVF_CLR];

    rpmp_event_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(ev_t))
    ) u_fifo (
        .gclk     (gclk),
        .reset    (reset),
        .push     (ev_valid),
        .push_dat (ev_in),
        .pop      (pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge gclk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ratn_s      <= 3'b000;
            r_out       <= 16'h0000;
            r_oe        <= 1'b0;
            rdata       <= 8'hFF;
            rdata_valid <= 1'b0;
            rwait       <= 1'b0;
            rint        <= 1'b1;
            claim_tbl   <= '0;
            overflow    <= 1'b0;
        end else begin
            ratn_s      <= {ratn_s[1:0], RATN};
            rdata_valid <= 1'b0;
            overflow    <= ovf_set | (overflow & ~ovf_clr);
            if (start) begin
                state <= ST_ACK;
                case (cmd)
                    CMD_PEEK_ADDR: begin
                        r_out <= fifo_empty ? 16'h0000 : head.addr;
                        r_oe  <= 1'b1;
                    end
                    CMD_POP_INFO: begin
                        r_out <= info_word(head, fifo_empty, overflow);
                        r_oe  <= 1'b1;
                    end
                    CMD_WRITE_DATA: begin
                        rdata       <= r_in[7:0];
                        rdata_valid <= 1'b1;
                        r_oe        <= 1'b0;
                    end
                    CMD_CONTROL: begin
                        rwait <= r_in[CTL_WAIT];
                        rint  <= r_in[CTL_INT];
                        if (r_in[CTL_CLAIM])        claim_tbl[r_in[7:0]] <= 1'b1;
                        else if (r_in[CTL_UNCLAIM]) claim_tbl[r_in[7:0]] <= 1'b0;
                        r_oe <= 1'b0;
                    end
                endcase
            end else if (fall && (state == ST_ACK)) begin
                state <= ST_IDLE;
                r_oe  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rpmp_host_link.sv
// Directed bench for rpmp_host_link: table of Pi handshakes plus overflow and reset-mid-handshake sequences.
module tb_rpmp_host_link;
    import rpmp_pkg::*;

    localparam int DEPTH = 8;

    logic        gclk = 1'b0;
    logic        reset;
    logic        ev_valid;
    logic        ev_ready;
    logic [15:0] ev_addr;
    logic [7:0]  ev_data;
    logic        ev_rw;
    logic        ev_iomem;
    logic        RATN;
    logic [1:0]  cmd;
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic        r_oe;
    logic        ack;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        rwait;
    logic        rint;
    logic [7:0]  io_port;
    logic        io_claimed;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 gclk = ~gclk;

    rpmp_host_link #(.DEPTH(DEPTH)) dut (
        .gclk        (gclk),
        .reset       (reset),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_addr     (ev_addr),
        .ev_data     (ev_data),
        .ev_rw       (ev_rw),
        .ev_iomem    (ev_iomem),
        .RATN        (RATN),
        .cmd         (cmd),
        .r_in        (r_in),
        .r_out       (r_out),
        .r_oe        (r_oe),
        .ack         (ack),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rwait       (rwait),
        .rint        (rint),
        .io_port     (io_port),
        .io_claimed  (io_claimed)
    );

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] rin;
        logic        chk_rout;
        logic [15:0] rout;
        logic        oe;
        logic [7:0]  rdata;
        int          pulses;
        logic        rwait;
        logic        rint;
        logic [7:0]  port;
        logic        claimed;
        int          count;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic [15:0] a, input logic [7:0] d, input logic rw, input logic io);
        @(posedge gclk); #1;
        ev_valid = 1'b1; ev_addr = a; ev_data = d; ev_rw = rw; ev_iomem = io;
        @(posedge gclk); #1;
        ev_valid = 1'b0;
    endtask

    // One full four-phase exchange; reports what was on r when ack rose.
    task automatic hs(input logic [1:0] c, input logic [15:0] v, output logic [15:0] ro,
                      output logic oe_at, output int lat, output int pulses, output logic oe_after);
        logic up_ok;
        logic dn_ok;
        up_ok = 1'b0; dn_ok = 1'b0; lat = 0; pulses = 0; ro = '0; oe_at = 1'b0;
        @(posedge gclk); #1;
        cmd = c; r_in = v; RATN = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge gclk); #1;
            if (rdata_valid) pulses++;
            if (ack) begin
                lat = i; ro = r_out; oe_at = r_oe; up_ok = 1'b1;
                break;
            end
        end
        chk("ack_rise", {31'b0, up_ok}, 32'd1);
        repeat (2) begin
            @(posedge gclk); #1;
            if (rdata_valid) pulses++;
            if (r_out !== ro) chk("r_out_stable", {16'b0, r_out}, {16'b0, ro});
        end
        RATN = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge gclk); #1;
            if (rdata_valid) pulses++;
            if (!ack) begin
                dn_ok = 1'b1;
                break;
            end
        end
        chk("ack_fall", {31'b0, dn_ok}, 32'd1);
        oe_after = r_oe;
    endtask

    logic [15:0] ro;
    logic        oe_at;
    logic        oe_after;
    int          lat;
    int          pulses;

    initial begin
        reset = 1'b1; ev_valid = 1'b0; ev_addr = '0; ev_data = '0; ev_rw = 1'b0; ev_iomem = 1'b0;
        RATN = 1'b0; cmd = 2'b00; r_in = '0; io_port = 8'hA8;

        vecs[0] = '{CMD_PEEK_ADDR,  16'h0000, 1'b1, 16'h8001, 1'b1, 8'hFF, 0, 1'b0, 1'b1, 8'hA8, 1'b0, 2};
        vecs[1] = '{CMD_POP_INFO,   16'h0000, 1'b1, 16'h005A, 1'b1, 8'hFF, 0, 1'b0, 1'b1, 8'hA8, 1'b0, 1};
        vecs[2] = '{CMD_POP_INFO,   16'h0000, 1'b1, 16'hC000, 1'b1, 8'hFF, 0, 1'b0, 1'b1, 8'hA8, 1'b0, 0};
        vecs[3] = '{CMD_POP_INFO,   16'h0000, 1'b1, 16'h2000, 1'b1, 8'hFF, 0, 1'b0, 1'b1, 8'hA8, 1'b0, 0};
        vecs[4] = '{CMD_PEEK_ADDR,  16'h0000, 1'b1, 16'h0000, 1'b1, 8'hFF, 0, 1'b0, 1'b1, 8'hA8, 1'b0, 0};
        vecs[5] = '{CMD_WRITE_DATA, 16'h003C, 1'b0, 16'h0000, 1'b0, 8'h3C, 1, 1'b0, 1'b1, 8'hA8, 1'b0, 0};
        vecs[6] = '{CMD_CONTROL,    16'hA0A8, 1'b0, 16'h0000, 1'b0, 8'h3C, 0, 1'b1, 1'b0, 8'hA8, 1'b1, 0};
        vecs[7] = '{CMD_CONTROL,    16'h50A8, 1'b0, 16'h0000, 1'b0, 8'h3C, 0, 1'b0, 1'b1, 8'hA8, 1'b0, 0};
        vecs[8] = '{CMD_CONTROL,    16'h3055, 1'b0, 16'h0000, 1'b0, 8'h3C, 0, 1'b0, 1'b0, 8'h55, 1'b1, 0};

        repeat (3) @(posedge gclk);
        #1 reset = 1'b0;
        @(negedge gclk);
        chk("rst_ack",      {31'b0, ack},         32'd0);
        chk("rst_r_out",    {16'b0, r_out},       32'h0);
        chk("rst_r_oe",     {31'b0, r_oe},        32'd0);
        chk("rst_rdata",    {24'b0, rdata},       32'hFF);
        chk("rst_rvalid",   {31'b0, rdata_valid}, 32'd0);
        chk("rst_rwait",    {31'b0, rwait},       32'd0);
        chk("rst_rint",     {31'b0, rint},        32'd1);
        chk("rst_ev_ready", {31'b0, ev_ready},    32'd1);
        chk("rst_claim",    {31'b0, io_claimed},  32'd0);

        push_ev(16'h8001, 8'h5A, 1'b0, 1'b0);
        push_ev(16'h0098, 8'h00, 1'b1, 1'b1);

        foreach (vecs[i]) begin
            hs(vecs[i].cmd, vecs[i].rin, ro, oe_at, lat, pulses, oe_after);
            if (vecs[i].chk_rout) chk($sformatf("v%0d_r_out", i), {16'b0, ro}, {16'b0, vecs[i].rout});
            chk($sformatf("v%0d_oe_at_ack", i), {31'b0, oe_at}, {31'b0, vecs[i].oe});
            chk($sformatf("v%0d_oe_after", i), {31'b0, oe_after}, 32'd0);
            chk($sformatf("v%0d_latency", i), {31'b0, (lat >= 3 && lat <= 4)}, 32'd1);
            chk($sformatf("v%0d_rdata", i), {24'b0, rdata}, {24'b0, vecs[i].rdata});
            chk($sformatf("v%0d_pulses", i), pulses, vecs[i].pulses);
            chk($sformatf("v%0d_rwait", i), {31'b0, rwait}, {31'b0, vecs[i].rwait});
            chk($sformatf("v%0d_rint", i), {31'b0, rint}, {31'b0, vecs[i].rint});
            io_port = vecs[i].port; #1;
            chk($sformatf("v%0d_claimed", i), {31'b0, io_claimed}, {31'b0, vecs[i].claimed});
            chk($sformatf("v%0d_count", i), 32'(dut.fifo_count), vecs[i].count);
            if (vecs[i].rin == 16'hA0A8) begin
                io_port = 8'hA9; #1;
                chk("claim_neighbour", {31'b0, io_claimed}, 32'd0);
            end
        end

        // Fill past capacity: last push is dropped and overflow latches.
        for (int i = 0; i <= DEPTH; i++) begin
            push_ev(16'h1000 + 16'(i), 8'h10 + 8'(i), 1'b0, 1'b0);
            chk($sformatf("fill%0d_ev_ready", i), {31'b0, ev_ready}, {31'b0, (i < DEPTH-1)});
        end
        chk("full_count", 32'(dut.fifo_count), DEPTH);
        hs(CMD_POP_INFO, 16'h0, ro, oe_at, lat, pulses, oe_after);
        chk("ovf_pop0", {16'b0, ro}, 32'h1010);
        chk("ovf_ready_back", {31'b0, ev_ready}, 32'd1);
        hs(CMD_PEEK_ADDR, 16'h0, ro, oe_at, lat, pulses, oe_after);
        chk("ovf_peek1", {16'b0, ro}, 32'h1001);
        for (int j = 1; j < DEPTH; j++) begin
            hs(CMD_POP_INFO, 16'h0, ro, oe_at, lat, pulses, oe_after);
            chk($sformatf("ovf_pop%0d", j), {16'b0, ro}, {16'b0, 16'h1010 + 16'(j)});
        end
        hs(CMD_POP_INFO, 16'h0, ro, oe_at, lat, pulses, oe_after);
        chk("ovf_empty_pop", {16'b0, ro}, 32'h3000);
        hs(CMD_CONTROL, 16'h0800, ro, oe_at, lat, pulses, oe_after);
        hs(CMD_POP_INFO, 16'h0, ro, oe_at, lat, pulses, oe_after);
        chk("ovf_cleared", {16'b0, ro}, 32'h2000);

        // Reset while ack is high.
        hs(CMD_CONTROL, 16'hA011, ro, oe_at, lat, pulses, oe_after);
        io_port = 8'h11; #1;
        chk("pre_rst_claim", {31'b0, io_claimed}, 32'd1);
        push_ev(16'h4444, 8'h44, 1'b0, 1'b0);
        @(posedge gclk); #1;
        cmd = CMD_PEEK_ADDR; RATN = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge gclk); #1;
            if (ack) begin lat = i; break; end
        end
        chk("mid_ack_up", {31'b0, ack}, 32'd1);
        chk("mid_r_out", {16'b0, r_out}, 32'h4444);
        reset = 1'b1; RATN = 1'b0;
        @(posedge gclk); #1;
        chk("mid_rst_ack",      {31'b0, ack},        32'd0);
        chk("mid_rst_r_oe",     {31'b0, r_oe},       32'd0);
        chk("mid_rst_r_out",    {16'b0, r_out},      32'h0);
        chk("mid_rst_count",    32'(dut.fifo_count), 32'd0);
        chk("mid_rst_ev_ready", {31'b0, ev_ready},   32'd1);
        chk("mid_rst_rwait",    {31'b0, rwait},      32'd0);
        chk("mid_rst_rint",     {31'b0, rint},       32'd1);
        chk("mid_rst_rdata",    {24'b0, rdata},      32'hFF);
        chk("mid_rst_claim",    {31'b0, io_claimed}, 32'd0);
        @(posedge gclk); #1;
        reset = 1'b0;
        repeat (5) @(posedge gclk);
        #1 chk("post_rst_idle", {31'b0, ack}, 32'd0);
        hs(CMD_POP_INFO, 16'h0, ro, oe_at, lat, pulses, oe_after);
        chk("post_rst_pop", {16'b0, ro}, 32'h2000);
        chk("post_rst_latency", {31'b0, (lat >= 3 && lat <= 4)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
